// File: rtl/halton_base3_decoder.sv
// halton_base3_decoder
//   Inverse of the base-3 Halton (radical-inverse) generator. A 24-bit
//   fraction is turned back into its ternary digits by repeated
//   multiply-by-3, one digit per clock.
//
//   The digits come out least-significant first. They are packed as a
//   binary-coded-ternary index, 2 bits per digit, in the same layout as
//   the generator's counter.
//
//   Optional feature: define HALTON_DEC_BIN_EN to also accumulate the
//   binary index sum(d_k * 3^k). Without it, out_bin is tied to zero.
//
//   Handshake:
//     - in_valid/in_ready on the input side.
//     - out_valid/out_ready on the output side.
//     - The result is held until it is consumed.
//   Reset is synchronous and active-high.
module halton_base3_decoder #(
  parameter int NDIG = 15  // digits to extract, 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_bct,
  output logic [23:0] out_bin
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] LAST_K   = 4'(NDIG - 1);

  // Half-LSB bias below the fraction.
  // Rounds the truncated fraction back onto the ternary grid so exact
  // thirds decode cleanly. It never carries into a digit within 15 steps.
  localparam logic [1:0] RND_BIAS = 2'b10;

  // 3*r without a multiplier: r + 2r, widened to keep the two carry-out
  // bits, which form the next ternary digit.
  function automatic logic [27:0] times3(input logic [25:0] r);
    times3 = {2'b00, r} + {1'b0, r, 1'b0};
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [31:0] out_bct_r;
  logic [25:0] res_r;
  logic [3:0]  k_r;

  logic        accept_s;
  logic        release_s;
  logic        step_s;
  logic        last_s;
  logic [27:0] prod_s;
  logic [1:0]  digit_s;
  logic [31:0] bct_nxt_s;

  assign accept_s  = in_valid & in_ready_r & (state_r == ST_IDLE);
  assign release_s = out_valid_r & out_ready & (state_r == ST_DONE);
  assign step_s    = (state_r == ST_CONV);
  assign last_s    = (k_r == LAST_K);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_bct   = out_bct_r;

  // Next-state logic: accept, convert NDIG digits, hold until consumed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_CONV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CONV;
        end
      end
      ST_DONE: begin
        if (release_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Digit extraction: the top two bits of 3*R are the next digit (0..2);
  // drop the digit into its 2-bit BCT slot selected by k.
  always_comb begin
    prod_s    = times3(res_r);
    digit_s   = prod_s[27:26];
    bct_nxt_s = out_bct_r;
    bct_nxt_s[{k_r, 1'b0} +: 2] = digit_s;
  end

  // Control registers: state, handshake flags and the digit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      k_r         <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            in_ready_r <= 1'b0;
            k_r        <= 4'd0;
          end
        end
        ST_CONV: begin
          k_r <= k_r + 4'd1;
          if (last_s) begin
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (release_s) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            k_r         <= 4'd0;
          end
        end
        default: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          k_r         <= 4'd0;
        end
      endcase
    end
  end

  // Datapath registers: load the biased residual on acceptance, then shift
  // one ternary digit out per CONV cycle. In DONE both hold their values.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_r     <= 26'd0;
      out_bct_r <= 32'h0000_0000;
    end else if (accept_s) begin
      res_r     <= {in_frac, RND_BIAS};
      out_bct_r <= 32'h0000_0000;
    end else if (step_s) begin
      res_r     <= prod_s[25:0];
      out_bct_r <= bct_nxt_s;
    end
  end

`ifdef HALTON_DEC_BIN_EN
  logic [23:0] weight_r;
  logic [23:0] out_bin_r;
  logic [23:0] addend_s;

  // Weighted digit: d_k * 3^k using only a shift, since d_k is at most 2.
  always_comb begin
    addend_s = 24'h000000;
    case (digit_s)
      2'd0:    addend_s = 24'h000000;
      2'd1:    addend_s = weight_r;
      2'd2:    addend_s = {weight_r[22:0], 1'b0};
      default: addend_s = 24'h000000;
    endcase
  end

  // Binary accumulator.
  // The weight starts at 3^0 on acceptance and triples every digit.
  // The largest possible sum, 3^15-1, still fits in 24 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      weight_r  <= 24'd0;
      out_bin_r <= 24'd0;
    end else if (accept_s) begin
      weight_r  <= 24'd1;
      out_bin_r <= 24'd0;
    end else if (step_s) begin
      weight_r  <= {weight_r[22:0], 1'b0} + weight_r;
      out_bin_r <= out_bin_r + addend_s;
    end
  end

  assign out_bin = out_bin_r;
`else
  assign out_bin = 24'h000000;
`endif

endmodule

// File: tb/tb_halton_base3_decoder.sv
// tb_halton_base3_decoder
//   Directed vectors with hand-computed BCT/binary indices.
//   The driver pushes the expected result into a queue at acceptance.
//   An independent monitor pops and compares on every output handshake,
//   and also checks the acceptance-to-valid latency.
module tb_halton_base3_decoder;

  localparam int NDIG = 15;
`ifdef HALTON_DEC_BIN_EN
  localparam bit BIN_EN = 1'b1;
`else
  localparam bit BIN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_frac;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_bct;
  logic [23:0] out_bin;

  typedef struct {
    logic [31:0] bct;
    logic [23:0] bin;
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  halton_base3_decoder #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_frac   (in_frac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bct   (out_bct),
    .out_bin   (out_bin)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time acceptance and valid.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_bin(input logic [23:0] b);
    return BIN_EN ? b : 24'h000000;
  endfunction

  // Scoreboard monitor: compare every consumed result against the queue head.
  initial begin : monitor
    exp_t e;
    logic prev_v;
    int   v_cyc;
    prev_v = 1'b0;
    v_cyc  = 0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_v) v_cyc = cyc;
      prev_v = out_valid;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", {out_bct}, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("out_bct", out_bct, e.bct);
          check("out_bin", {8'h00, out_bin}, {8'h00, e.bin});
          check("latency", 32'(v_cyc - e.acc_cyc), 32'(NDIG));
        end
      end
    end
  end

  // Offer one fraction; record the expectation when it is accepted.
  task automatic send(input logic [23:0] frac, input logic [31:0] bct, input logic [23:0] bin);
    exp_t e;
    int   n;
    n        = 0;
    in_frac  = frac;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.bct     = bct;
    e.bin     = exp_bin(bin);
    e.acc_cyc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_frac  = ~frac;  // must not affect the conversion in flight
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : driver
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_frac   = 24'h000000;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_bct",   out_bct,            32'h0000_0000);
    check("rst_out_bin",   {8'h00, out_bin},   32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic vectors, issued back to back.
    send(24'h000000, 32'h0000_0000, 24'd0);
    send(24'h555555, 32'h0000_0001, 24'd1);
    send(24'hAAAAAB, 32'h0000_0002, 24'd2);
    send(24'h1C71C7, 32'h0000_0004, 24'd3);
    send(24'hFFFFFF, 32'h2AAA_AAAA, 24'hDAF26A);
    drain();

    // Backpressure: 0.5 decodes to all-ones digits; hold the result for 10 cycles.
    out_ready = 1'b0;
    send(24'h800000, 32'h1555_5555, 24'h6D7935);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b1;
    in_frac  = 24'h123456;
    repeat (10) begin
      @(negedge clk);
      check("bp_valid_hold", {31'b0, out_valid}, 32'd1);
      check("bp_bct_stable", out_bct, 32'h1555_5555);
      check("bp_bin_stable", {8'h00, out_bin}, {8'h00, exp_bin(24'h6D7935)});
      check("bp_in_ready",   {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready",  {31'b0, in_ready},  32'd1);
    check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    check("bp_queue_empty", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a conversion discards the result.
    send(24'h555555, 32'h0000_0001, 24'd1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_bct",   out_bct,            32'h0000_0000);
    check("midrst_out_bin",   {8'h00, out_bin},   32'd0);
    check("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    if (sb_q.size() != 0) sb_q.delete(sb_q.size() - 1);
    send(24'h555555, 32'h0000_0001, 24'd1);
    drain();

    // Nothing further may appear.
    repeat (20) @(negedge clk);
    check("idle_out_valid", {31'b0, out_valid}, 32'd0);
    check("final_queue",    32'(sb_q.size()),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
